// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for result-bus producers and consumers.
//   station_index_width(count): width of a station index field, never below 1
//   so that a single-station configuration still has a legal vector width.
package bus_arbiter_pkg;

  function automatic int station_index_width(input int count);
    int w;
    w = $clog2(count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Purely combinational round-robin selector.
// Scans the request vector starting at ptr, wrapping modulo STATION_COUNT, and
// hands the first BUS_COUNT requesters to buses 0, 1, ... in scan order.
// Ports:
//   request   in  [STATION_COUNT]  per-station request
//   ptr       in  [IW]             first station in scan order
//   bus_valid out [BUS_COUNT]      bus j has a selected station
//   bus_index out [BUS_COUNT][IW]  station selected for bus j (0 when idle)
//   grant     out [STATION_COUNT]  per-station selection
//   next_ptr  out [IW]             one past the last selected station, or ptr
//                                  when nothing is selected
module rr_priority_picker
  import bus_arbiter_pkg::*;
#(
  parameter  int STATION_COUNT = 4,
  parameter  int BUS_COUNT     = 2,
  localparam int IW            = station_index_width(STATION_COUNT)
) (
  input  logic [STATION_COUNT-1:0] request,
  input  logic [IW-1:0]            ptr,
  output logic [BUS_COUNT-1:0]     bus_valid,
  output logic [IW-1:0]            bus_index [BUS_COUNT],
  output logic [STATION_COUNT-1:0] grant,
  output logic [IW-1:0]            next_ptr
);

  always_comb begin
    int idx;
    int cnt;
    logic req_at;
    grant     = '0;
    bus_valid = '0;
    next_ptr  = ptr;
    idx       = 0;
    cnt       = 0;
    req_at    = 1'b0;
    for (int j = 0; j < BUS_COUNT; j++) bus_index[j] = '0;
    for (int k = 0; k < STATION_COUNT; k++) begin
      idx = (int'(ptr) + k) % STATION_COUNT;
      // Constant-index loops keep every select within its declared range.
      req_at = 1'b0;
      for (int s = 0; s < STATION_COUNT; s++) begin
        if (s == idx) req_at = request[s];
      end
      if (req_at && (cnt < BUS_COUNT)) begin
        for (int s = 0; s < STATION_COUNT; s++) begin
          if (s == idx) grant[s] = 1'b1;
        end
        for (int j = 0; j < BUS_COUNT; j++) begin
          if (j == cnt) begin
            bus_valid[j] = 1'b1;
            bus_index[j] = IW'(idx);
          end
        end
        next_ptr = IW'((idx + 1) % STATION_COUNT);
        cnt      = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/round_robin_bus_arbiter.sv
// Registered round-robin arbiter placing station results onto shared result
// buses. Priority rotates past the last granted station so nobody starves.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   flush                     suppress grants, idle all buses next cycle
//   station_ready/value       per-station result offer
//   station_grant             combinational accept for this edge
//   bus_asserted/source/value registered bus contents
//
// Handshake: a station raises station_ready with a stable station_value and
// holds both until the cycle station_grant is 1; the result is captured at
// that clock edge and appears on the bus for the following cycle. Dropping
// ready without a grant is allowed and captures nothing.
module round_robin_bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter  int SIZE               = 32,
  parameter  int STATION_COUNT      = 4,
  parameter  int BUS_COUNT          = 2,
  localparam int STATION_INDEX_SIZE = station_index_width(STATION_COUNT)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [STATION_COUNT-1:0]      station_ready,
  input  logic [SIZE-1:0]               station_value [STATION_COUNT],
  output logic [STATION_COUNT-1:0]      station_grant,
  output logic [BUS_COUNT-1:0]          bus_asserted,
  output logic [STATION_INDEX_SIZE-1:0] bus_source [BUS_COUNT],
  output logic [SIZE-1:0]               bus_value [BUS_COUNT]
);

  logic [STATION_INDEX_SIZE-1:0] ptr;
  logic [STATION_INDEX_SIZE-1:0] next_ptr;
  logic [BUS_COUNT-1:0]          pick_valid;
  logic [STATION_INDEX_SIZE-1:0] pick_index [BUS_COUNT];
  logic [STATION_COUNT-1:0]      pick_grant;
  logic [SIZE-1:0]               sel_value [BUS_COUNT];
  logic                          accept;

  rr_priority_picker #(
    .STATION_COUNT (STATION_COUNT),
    .BUS_COUNT     (BUS_COUNT)
  ) u_picker (
    .request   (station_ready),
    .ptr       (ptr),
    .bus_valid (pick_valid),
    .bus_index (pick_index),
    .grant     (pick_grant),
    .next_ptr  (next_ptr)
  );

  // Nothing is accepted while reset or flush is high, so pending results
  // stay with their stations.
  assign accept        = !reset && !flush;
  assign station_grant = accept ? pick_grant : '0;

  always_comb begin
    for (int j = 0; j < BUS_COUNT; j++) begin
      sel_value[j] = '0;
      for (int s = 0; s < STATION_COUNT; s++) begin
        if (pick_index[j] == STATION_INDEX_SIZE'(s)) sel_value[j] = station_value[s];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr          <= '0;
      bus_asserted <= '0;
      for (int j = 0; j < BUS_COUNT; j++) begin
        bus_source[j] <= '0;
        bus_value[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < BUS_COUNT; j++) begin
        if (accept && pick_valid[j]) begin
          bus_asserted[j] <= 1'b1;
          bus_source[j]   <= pick_index[j];
          bus_value[j]    <= sel_value[j];
        end else begin
          bus_asserted[j] <= 1'b0;
          bus_source[j]   <= '0;
          bus_value[j]    <= '0;
        end
      end
      if (accept && (|pick_grant)) ptr <= next_ptr;
    end
  end

endmodule

// File: tb/tb_round_robin_bus_arbiter.sv
module tb_round_robin_bus_arbiter;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [3:0]  station_ready;
  logic [31:0] station_value [4];
  logic [3:0]  station_grant;
  logic [1:0]  bus_asserted;
  logic [1:0]  bus_source [2];
  logic [31:0] bus_value [2];

  // Single-bus instance for the starvation scenario.
  logic [3:0]  ready1;
  logic [3:0]  grant1;
  logic [0:0]  asserted1;
  logic [1:0]  source1 [1];
  logic [31:0] value1 [1];

  int checks = 0;
  int errors = 0;

  round_robin_bus_arbiter #(.SIZE(32), .STATION_COUNT(4), .BUS_COUNT(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .station_ready (station_ready),
    .station_value (station_value),
    .station_grant (station_grant),
    .bus_asserted  (bus_asserted),
    .bus_source    (bus_source),
    .bus_value     (bus_value)
  );

  round_robin_bus_arbiter #(.SIZE(32), .STATION_COUNT(4), .BUS_COUNT(1)) dut1 (
    .clock         (clock),
    .reset         (reset),
    .flush         (1'b0),
    .station_ready (ready1),
    .station_value (station_value),
    .station_grant (grant1),
    .bus_asserted  (asserted1),
    .bus_source    (source1),
    .bus_value     (value1)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Driver: apply ready vector, let combinational grants settle.
  task automatic drive(input logic [3:0] rdy, input logic fl);
    station_ready = rdy;
    flush         = fl;
    #1;
  endtask

  task automatic chk_bus(input string tag, input int j, input logic a,
                         input logic [1:0] src, input logic [31:0] val);
    chk({tag, "_asserted"}, 64'(bus_asserted[j]), 64'(a));
    chk({tag, "_source"}, 64'(bus_source[j]), 64'(src));
    chk({tag, "_value"}, 64'(bus_value[j]), 64'(val));
  endtask

  initial begin
    station_value[0] = 32'hA;
    station_value[1] = 32'hB;
    station_value[2] = 32'hC;
    station_value[3] = 32'hD;
    ready1 = 4'b0000;

    // Reset held 2 cycles with everyone ready.
    reset = 1'b1;
    drive(4'b1111, 1'b0);
    chk("reset_grant_c0", 64'(station_grant), 64'h0);
    tick();
    chk("reset_grant_c1", 64'(station_grant), 64'h0);
    tick();
    reset = 1'b0;
    drive(4'b0000, 1'b0);
    chk_bus("reset_bus0", 0, 1'b0, 2'd0, 32'h0);
    chk_bus("reset_bus1", 1, 1'b0, 2'd0, 32'h0);
    chk("reset_ptr", 64'(dut.ptr), 64'd0);

    // Rotation: all ready for 4 cycles.
    drive(4'b1111, 1'b0);
    chk("rot0_grant", 64'(station_grant), 64'b0011);
    tick();
    chk_bus("rot0_bus0", 0, 1'b1, 2'd0, 32'hA);
    chk_bus("rot0_bus1", 1, 1'b1, 2'd1, 32'hB);
    chk("rot0_ptr", 64'(dut.ptr), 64'd2);
    chk("rot1_grant", 64'(station_grant), 64'b1100);
    tick();
    chk_bus("rot1_bus0", 0, 1'b1, 2'd2, 32'hC);
    chk_bus("rot1_bus1", 1, 1'b1, 2'd3, 32'hD);
    chk("rot1_ptr", 64'(dut.ptr), 64'd0);
    chk("rot2_grant", 64'(station_grant), 64'b0011);
    tick();
    chk("rot2_ptr", 64'(dut.ptr), 64'd2);
    chk("rot3_grant", 64'(station_grant), 64'b1100);
    tick();
    chk("rot3_ptr", 64'(dut.ptr), 64'd0);

    // Basic: stations 1..3 ready, ptr 0 -> stations 1 and 2 granted.
    drive(4'b1110, 1'b0);
    chk("basic_grant", 64'(station_grant), 64'b0110);
    tick();
    chk_bus("basic_bus0", 0, 1'b1, 2'd1, 32'hB);
    chk_bus("basic_bus1", 1, 1'b1, 2'd2, 32'hC);
    chk("basic_ptr", 64'(dut.ptr), 64'd3);
    drive(4'b0000, 1'b0);
    chk("idle_grant", 64'(station_grant), 64'h0);
    tick();
    chk("idle_asserted", 64'(bus_asserted), 64'h0);
    chk("idle_ptr", 64'(dut.ptr), 64'd3);

    // Flush with 3 ready: no grants, buses idle, ptr held.
    drive(4'b1011, 1'b1);
    chk("flush_grant", 64'(station_grant), 64'h0);
    tick();
    chk_bus("flush_bus0", 0, 1'b0, 2'd0, 32'h0);
    chk_bus("flush_bus1", 1, 1'b0, 2'd0, 32'h0);
    chk("flush_ptr", 64'(dut.ptr), 64'd3);
    drive(4'b1011, 1'b0);
    chk("post_flush_grant", 64'(station_grant), 64'b1001);
    tick();
    chk_bus("post_flush_bus0", 0, 1'b1, 2'd3, 32'hD);
    chk_bus("post_flush_bus1", 1, 1'b1, 2'd0, 32'hA);
    chk("post_flush_ptr", 64'(dut.ptr), 64'd1);

    // Two active cycles to bring ptr to 2, then reset mid-operation.
    drive(4'b0110, 1'b0);
    chk("pre_rst0_grant", 64'(station_grant), 64'b0110);
    tick();
    chk("pre_rst0_ptr", 64'(dut.ptr), 64'd3);
    drive(4'b0011, 1'b0);
    chk("pre_rst1_grant", 64'(station_grant), 64'b0011);
    tick();
    chk("pre_rst1_ptr", 64'(dut.ptr), 64'd2);
    reset = 1'b1;
    drive(4'b1111, 1'b1);  // reset with flush: reset dominates
    chk("midrst_grant", 64'(station_grant), 64'h0);
    tick();
    chk_bus("midrst_bus0", 0, 1'b0, 2'd0, 32'h0);
    chk_bus("midrst_bus1", 1, 1'b0, 2'd0, 32'h0);
    chk("midrst_ptr", 64'(dut.ptr), 64'd0);
    reset = 1'b0;
    drive(4'b1010, 1'b0);
    chk("after_rst_grant", 64'(station_grant), 64'b1010);
    tick();
    chk_bus("after_rst_bus0", 0, 1'b1, 2'd1, 32'hB);
    chk_bus("after_rst_bus1", 1, 1'b1, 2'd3, 32'hD);
    drive(4'b0000, 1'b0);

    // Starvation, one bus: stations 0, 1, 3 ready continuously.
    // Expected grant order 0, 1, 3, 0, 1, 3.
    ready1 = 4'b1011;
    #1;
    begin
      logic [3:0] exp_grant [6];
      logic [1:0] exp_src [6];
      exp_grant[0] = 4'b0001; exp_src[0] = 2'd0;
      exp_grant[1] = 4'b0010; exp_src[1] = 2'd1;
      exp_grant[2] = 4'b1000; exp_src[2] = 2'd3;
      exp_grant[3] = 4'b0001; exp_src[3] = 2'd0;
      exp_grant[4] = 4'b0010; exp_src[4] = 2'd1;
      exp_grant[5] = 4'b1000; exp_src[5] = 2'd3;
      for (int c = 0; c < 6; c++) begin
        chk($sformatf("starve_grant_c%0d", c), 64'(grant1), 64'(exp_grant[c]));
        tick();
        chk($sformatf("starve_asserted_c%0d", c), 64'(asserted1), 64'h1);
        chk($sformatf("starve_source_c%0d", c), 64'(source1[0]), 64'(exp_src[c]));
      end
    end
    ready1 = 4'b0000;
    tick();
    chk("starve_idle", 64'(asserted1), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
